sd_frame_buf_ctrl: RTL and testbench
====================================

SD_FRAME_BUF_CTRL -- requirements
Module: sd_frame_buf_ctrl

Interface
REQ-001 The block SHALL be parameterised by: DW, 16, sample width (signed two's complement).
REQ-002 The block SHALL be parameterised by: DEPTH, 14, samples per frame.
REQ-003 The block SHALL be parameterised by: AW, 4, address width; AW SHALL satisfy 2**AW >= DEPTH.
REQ-004 The block SHALL have ports exactly as follows; one clock, reset asynchronous and active-high:
  clk        in   1    clock, all state on rising edge
  rst        in   1    asynchronous active-high reset
  in_valid   in   1    input sample valid
  in_ready   out  1    block accepts input sample
  in_data    in   DW   signed real-part sample
  out_valid  out  1    output sample valid
  out_ready  in   1    downstream accepts output sample
  out_data   out  DW   signed sample read from buffer
  out_addr   out  AW   frame index of out_data
  out_last   out  1    out_data is index DEPTH-1
  busy       out  1    high in FILL or DRAIN
  replay     in   1    restart drain of stored frame (SD_BUF_REPLAY_EN only)

Function
REQ-005 Handshakes SHALL be valid/ready: a transfer occurs in a cycle where valid && ready; valid SHALL NOT depend combinationally on ready.
REQ-006 The FSM SHALL have exactly three states: IDLE, FILL and DRAIN.
REQ-007 IDLE: in_ready=1; on an in_valid transfer, write sample to address 0, set wr_ptr=1, go to FILL.
REQ-008 FILL: in_ready=1; each transfer writes in_data to address wr_ptr and increments wr_ptr. The transfer at wr_ptr=DEPTH-1 SHALL go to DRAIN with rd_ptr=0.
REQ-009 DRAIN: in_ready=0. The block SHALL issue a RAM read of address rd_ptr when (!out_valid || out_ready) and rd_ptr<DEPTH, then increment rd_ptr.
REQ-010 RAM read latency SHALL be 1 cycle. out_valid SHALL be high the cycle after an issued read. out_data SHALL be taken directly from the RAM registered output.
REQ-011 When out_valid && !out_ready, the RAM enable SHALL be low, so out_data, out_addr and out_last hold stable until accepted.
REQ-012 Full-rate drain: with out_ready held high, the block SHALL deliver one sample per cycle. The first sample appears 1 cycle after entering DRAIN.
REQ-013 The transfer with out_last=1 SHALL return the FSM to IDLE. out_valid SHALL be 0 the next cycle unless a new read is issued.
REQ-014 Minimum frame turnaround SHALL be DEPTH input cycles + 1 + DEPTH output cycles. IDLE SHALL accept a new first sample in the cycle after the last output transfer.
REQ-015 Address wrap: wr_ptr and rd_ptr SHALL never exceed DEPTH-1 as RAM addresses. Addresses DEPTH..2**AW-1 SHALL never be accessed.
REQ-016 in_valid during DRAIN SHALL be ignored (in_ready=0); no write occurs. out_ready while out_valid=0 SHALL have no effect.
REQ-017 busy SHALL be 1 in FILL and DRAIN and 0 in IDLE.

Reset
REQ-018 On rst, the block SHALL asynchronously enter IDLE with wr_ptr=0, rd_ptr=0, out_valid=0, out_last=0, out_addr=0, busy=0 and in_ready=1 after release.
REQ-019 Reset mid-FILL or mid-DRAIN SHALL abandon the frame. RAM contents are not cleared, and out_data is undefined until the next read.

Configuration
REQ-020 Macro SD_BUF_REPLAY_EN defined: replay=1 in IDLE, with at least one complete frame stored since reset, SHALL enter DRAIN with rd_ptr=0 and re-deliver the stored frame unchanged.
REQ-021 If replay and in_valid are both high in IDLE, replay SHALL win and in_ready SHALL be 0 that cycle. replay outside IDLE, or before any complete frame, SHALL be ignored.
REQ-022 Macro SD_BUF_REPLAY_EN undefined: the replay port and the frame-stored flag SHALL be absent, and behaviour SHALL be per REQ-007..REQ-019 only.

Structure
REQ-023 Package sd_buf_pkg SHALL hold the FSM state enum (IDLE, FILL, DRAIN) and the default constants SD_DW=16, SD_DEPTH=14 and SD_AW=4.
REQ-024 Storage SHALL be a single sub-module sd_buf_ram: single-port, DEPTH x DW, block-RAM style, synchronous write and registered read with en/we, holding dout when en=0.

Verification
REQ-025 Write 14 samples 0x0001..0x000E back-to-back, then out_ready=1 -> 14 outputs in consecutive cycles, addr 0..13, out_last only on 0x000E, busy falls after the last transfer.
REQ-026 Drain with out_ready toggled 1,0,0,1 per cycle using samples -32768, 32767, -1 -> each output held stable while stalled, no loss or duplication, sign preserved.
REQ-027 Drive in_valid=1 with 0x7FFF throughout DRAIN -> no writes occur, and the stored frame drains unchanged.
REQ-028 Assert rst after 7 FILL transfers, then load a fresh frame 0x0100..0x010D -> output exactly 0x0100..0x010D.
REQ-029 With SD_BUF_REPLAY_EN: after a full drain, pulse replay with in_valid=1 -> the identical 14-sample frame is re-delivered, and in_ready=0 in the pulse cycle.

Source files
------------

// File: rtl/sd_frame_buf_ctrl_pkg.sv
// Shared types and default sizing for the sample frame buffer controller.
// The optional SD_BUF_REPLAY_EN build reuses these definitions unchanged.
package sd_buf_pkg;

    localparam int SD_DW    = 16;
    localparam int SD_DEPTH = 14;
    localparam int SD_AW    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } buf_state_t;

endpackage

// File: rtl/sd_frame_buf_ctrl_if.sv
// Stream-in / stream-out handshake bundle for the frame buffer controller.
// The replay input exists only when SD_BUF_REPLAY_EN is defined.
interface sd_frame_buf_ctrl_if
    import sd_buf_pkg::*;
#(
    parameter int DW = SD_DW,
    parameter int AW = SD_AW
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
`ifdef SD_BUF_REPLAY_EN
    logic          replay;
`endif

    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef SD_BUF_REPLAY_EN
        input  replay,
`endif
        output in_ready, out_valid, out_data, out_addr, out_last, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
`ifdef SD_BUF_REPLAY_EN
        output replay,
`endif
        input  in_ready, out_valid, out_data, out_addr, out_last, busy
    );

endinterface

// File: rtl/sd_frame_buf_ctrl_ram.sv
// Single-port DEPTH x DW block RAM: synchronous write, registered read,
// output register holds its value whenever en is low.
module sd_buf_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 14,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= din;
            end else begin
                dout <= r_mem[addr];
            end
        end
    end

endmodule

// File: rtl/sd_frame_buf_ctrl.sv
// Frame buffer controller: collects DEPTH samples, then streams them out with
// valid/ready backpressure. Optional SD_BUF_REPLAY_EN re-drains the last frame.
module sd_frame_buf_ctrl
    import sd_buf_pkg::*;
#(
    parameter int DW    = SD_DW,
    parameter int DEPTH = SD_DEPTH,
    parameter int AW    = SD_AW
) (
    input  logic               clk,
    input  logic               rst,
    sd_frame_buf_ctrl_if.slave bus
);

    buf_state_t    r_state;
    buf_state_t    w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_out_valid;
    logic          r_out_last;
    logic [AW-1:0] r_out_addr;

    logic          w_ram_en;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_dout;
    logic          w_in_ready;
    logic          w_rd_issue;
    logic          w_replay_go;
    logic          w_out_xfer;

`ifdef SD_BUF_REPLAY_EN
    logic          r_frame_stored;
    assign w_replay_go = (r_state == IDLE) && bus.replay && r_frame_stored;
`else
    assign w_replay_go = 1'b0;
`endif

    assign w_out_xfer = r_out_valid && bus.out_ready;
    // rd_ptr is one bit wider so it can reach DEPTH and stop issuing reads
    assign w_rd_issue = (r_state == DRAIN) && (!r_out_valid || bus.out_ready)
                        && (r_rd_ptr < (AW+1)'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        case (r_state)
            IDLE: begin
                w_in_ready = !w_replay_go;
                if (w_replay_go) begin
                    w_state_nxt = DRAIN;
                end else if (bus.in_valid) begin
                    w_ram_en    = 1'b1;
                    w_ram_we    = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_ram_en   = 1'b1;
                    w_ram_we   = 1'b1;
                    w_ram_addr = r_wr_ptr;
                    if (r_wr_ptr == AW'(DEPTH - 1)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_rd_issue) begin
                    w_ram_en   = 1'b1;
                    w_ram_addr = r_rd_ptr[AW-1:0];
                end
                if (w_out_xfer && r_out_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_addr  <= '0;
        end else begin
            // wrapping after DEPTH-1 leaves wr_ptr at 0 for the next frame
            if (w_ram_we) begin
                r_wr_ptr <= (w_ram_addr == AW'(DEPTH - 1)) ? '0 : w_ram_addr + 1'b1;
            end
            if (r_state != DRAIN && w_state_nxt == DRAIN) begin
                r_rd_ptr <= '0;
            end else if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_rd_issue) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= r_rd_ptr[AW-1:0];
                r_out_last  <= (r_rd_ptr == (AW+1)'(DEPTH - 1));
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

`ifdef SD_BUF_REPLAY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_stored <= 1'b0;
        end else if (r_state == FILL && w_state_nxt == DRAIN) begin
            r_frame_stored <= 1'b1;
        end
    end
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = w_ram_dout;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state != IDLE);

    sd_buf_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk  (clk),
        .en   (w_ram_en),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .din  (bus.in_data),
        .dout (w_ram_dout)
    );

endmodule

// File: tb/tb_sd_frame_buf_ctrl.sv
// Scoreboard bench for sd_frame_buf_ctrl; replay checks run when SD_BUF_REPLAY_EN is defined.
module tb_sd_frame_buf_ctrl;
    import sd_buf_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 14;
    localparam int AW    = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          l;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    sd_frame_buf_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    sd_frame_buf_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [DW-1:0] m_frame        [DEPTH];
    logic [DW-1:0] m_stored_frame [DEPTH];
    int            m_n_in = 0;
    bit            m_draining = 0;
    bit            m_stored = 0;
    int            m_out_idx = 0;
    int            m_last_in = 0;
    int            m_prev_out = 0;
    int            cyc = 0;
    exp_t          q[$];

    int            mode = 0;
    logic [3:0]    pat = 4'b1001;
    int            pi = 0;
    logic [DW-1:0] smp [DEPTH];

    bit            prev_stall = 0;
    logic [DW-1:0] h_data;
    logic [AW-1:0] h_addr;
    logic          h_last;
    exp_t          e;
    bit            exp_rdy;
    bit            rgo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_stored();
        exp_t x;
        for (int i = 0; i < DEPTH; i++) begin
            x.d = m_stored_frame[i];
            x.a = AW'(i);
            x.l = (i == DEPTH - 1);
            q.push_back(x);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (mode)
            0: bus.out_ready = 1'b1;
            1: begin
                bus.out_ready = pat[pi];
                pi = (pi + 1) % 4;
            end
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // monitor: observes mid-cycle, predicts the transfers at the next rising edge
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            m_n_in     = 0;
            m_draining = 0;
            m_stored   = 0;
            m_out_idx  = 0;
            prev_stall = 0;
        end else begin
            rgo = 0;
`ifdef SD_BUF_REPLAY_EN
            rgo = bus.replay && m_stored && !m_draining && (m_n_in == 0);
`endif
            exp_rdy = !m_draining && !rgo;
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("busy", 32'(bus.busy), 32'(m_draining || m_n_in > 0));
            if (!m_draining) chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_data", 32'(bus.out_data), 32'(h_data));
                chk("hold_addr", 32'(bus.out_addr), 32'(h_addr));
                chk("hold_last", 32'(bus.out_last), 32'(h_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %0h addr %0d, expected no output", bus.out_data, bus.out_addr);
                end else begin
                    e = q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.d));
                    chk("out_addr", 32'(bus.out_addr), 32'(e.a));
                    chk("out_last", 32'(bus.out_last), 32'(e.l));
                    if (mode == 0)
                        chk("full_rate_cycle", 32'(cyc), 32'((m_out_idx == 0) ? m_last_in + 2 : m_prev_out + 1));
                    m_prev_out = cyc;
                    m_out_idx++;
                    if (e.l) begin
                        m_draining = 0;
                        m_out_idx  = 0;
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            h_data = bus.out_data;
            h_addr = bus.out_addr;
            h_last = bus.out_last;
            if (rgo) begin
                push_stored();
                m_draining = 1;
                m_last_in  = cyc;
            end else if (bus.in_valid && exp_rdy) begin
                m_frame[m_n_in] = bus.in_data;
                m_n_in++;
                if (m_n_in == DEPTH) begin
                    m_stored_frame = m_frame;
                    m_stored   = 1;
                    push_stored();
                    m_draining = 1;
                    m_n_in     = 0;
                    m_last_in  = cyc;
                end
            end
        end
    end

    task automatic send(input int n, input bit gaps);
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = smp[i];
            acc = 0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0, expected acceptance of sample %0d", i);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((m_draining || q.size() != 0) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs pending, expected 0", q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_checks();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_checks();
    endtask

    initial begin
        int t;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
`ifdef SD_BUF_REPLAY_EN
        bus.replay   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_checks();

        // counting frame, full-rate drain
        mode = 0;
        for (int i = 0; i < DEPTH; i++) smp[i] = DW'(i + 1);
        send(DEPTH, 0);
        wait_idle();

        // extreme signed values with 1,0,0,1 backpressure
        mode = 1;
        for (int i = 0; i < DEPTH; i++)
            smp[i] = (i % 3 == 0) ? 16'h8000 : (i % 3 == 1) ? 16'h7FFF : 16'hFFFF;
        send(DEPTH, 0);
        wait_idle();

        // in_valid held with 0x7FFF throughout the drain
        mode = 2;
        for (int i = 0; i < DEPTH; i++) smp[i] = DW'($urandom);
        send(DEPTH, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7FFF;
        t = 0;
        while (bus.busy && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        bus.in_valid = 1'b0;
        wait_idle();

        // reset mid-fill abandons the partial frame
        mode = 0;
        for (int i = 0; i < DEPTH; i++) smp[i] = DW'($urandom);
        send(7, 0);
        do_reset();
`ifdef SD_BUF_REPLAY_EN
        bus.replay = 1'b1;
        @(posedge clk); #1;
        bus.replay = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif
        for (int i = 0; i < DEPTH; i++) smp[i] = DW'(16'h0100 + i);
        send(DEPTH, 0);
        wait_idle();

        // random frames, random gaps and backpressure
        for (int f = 0; f < 4; f++) begin
            mode = f % 3;
            for (int i = 0; i < DEPTH; i++) smp[i] = DW'($urandom);
            send(DEPTH, 1);
            wait_idle();
        end

`ifdef SD_BUF_REPLAY_EN
        mode = 0;
        bus.replay   = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5555;
        @(posedge clk); #1;
        bus.replay   = 1'b0;
        bus.in_valid = 1'b0;
        wait_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
